ps2_kbd_decode: RTL and testbench



---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_kbd_decode_if.sv | 25 ++
 rtl/ps2_kbd_map.sv | 53 +++++
 rtl/ps2_kbd_decode.sv | 155 +++++++++++++++
 tb/tb_ps2_kbd_decode.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_pkg: scancode/ASCII constants, prefix FSM states, keymap entry |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] SC_E0       = 8'hE0;
  localparam logic [7:0] SC_F0       = 8'hF0;
  localparam logic [7:0] SC_E1       = 8'hE1;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_ESC      = 8'h76;
  localparam logic [7:0] SC_TAB      = 8'h0D;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  localparam logic [6:0] ASC_CR     = 7'h0D;
  localparam logic [6:0] ASC_ESC    = 7'h1B;
  localparam logic [6:0] ASC_RUBOUT = 7'h7F;
  localparam logic [6:0] ASC_TAB    = 7'h09;
  localparam logic [6:0] ASC_SPACE  = 7'h20;
  localparam logic [6:0] ASC_SLASH  = 7'h2F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [6:0] unshifted;
    logic [6:0] shifted;
    logic       is_letter;
  } map_entry_t;

  // Keyboard self-test/ack/resend replies carry no key information.
  function automatic logic is_discard(input logic [7:0] code);
    return code inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_decode_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_kbd_decode_if: scancode input and console character handshake  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ps2_kbd_decode_if;
  logic [7:0] sc;
  logic       sc_parity;
  logic       sc_rdy;
  logic       sc_error;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ack;

  modport master (
    output sc, sc_parity, sc_rdy, sc_error, char_ack,
    input  char, char_valid
  );

  modport slave (
    input  sc, sc_parity, sc_rdy, sc_error, char_ack,
    output char, char_valid
  );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_map.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_kbd_map: Set-2 scancode to unshifted/shifted 7-bit ASCII ROM   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_kbd_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output map_entry_t entry
);

  function automatic map_entry_t mk_letter(input logic [6:0] lower);
    return '{hit: 1'b1, unshifted: lower, shifted: lower - 7'h20, is_letter: 1'b1};
  endfunction

  function automatic map_entry_t mk_pair(input logic [6:0] lo, input logic [6:0] hi);
    return '{hit: 1'b1, unshifted: lo, shifted: hi, is_letter: 1'b0};
  endfunction

  always_comb begin
    entry = '0;
    case (code)
      8'h1C: entry = mk_letter(7'h61);  8'h32: entry = mk_letter(7'h62);
      8'h21: entry = mk_letter(7'h63);  8'h23: entry = mk_letter(7'h64);
      8'h24: entry = mk_letter(7'h65);  8'h2B: entry = mk_letter(7'h66);
      8'h34: entry = mk_letter(7'h67);  8'h33: entry = mk_letter(7'h68);
      8'h43: entry = mk_letter(7'h69);  8'h3B: entry = mk_letter(7'h6A);
      8'h42: entry = mk_letter(7'h6B);  8'h4B: entry = mk_letter(7'h6C);
      8'h3A: entry = mk_letter(7'h6D);  8'h31: entry = mk_letter(7'h6E);
      8'h44: entry = mk_letter(7'h6F);  8'h4D: entry = mk_letter(7'h70);
      8'h15: entry = mk_letter(7'h71);  8'h2D: entry = mk_letter(7'h72);
      8'h1B: entry = mk_letter(7'h73);  8'h2C: entry = mk_letter(7'h74);
      8'h3C: entry = mk_letter(7'h75);  8'h2A: entry = mk_letter(7'h76);
      8'h1D: entry = mk_letter(7'h77);  8'h22: entry = mk_letter(7'h78);
      8'h35: entry = mk_letter(7'h79);  8'h1A: entry = mk_letter(7'h7A);
      8'h45: entry = mk_pair(7'h30, 7'h29);  8'h16: entry = mk_pair(7'h31, 7'h21);
      8'h1E: entry = mk_pair(7'h32, 7'h40);  8'h26: entry = mk_pair(7'h33, 7'h23);
      8'h25: entry = mk_pair(7'h34, 7'h24);  8'h2E: entry = mk_pair(7'h35, 7'h25);
      8'h36: entry = mk_pair(7'h36, 7'h5E);  8'h3D: entry = mk_pair(7'h37, 7'h26);
      8'h3E: entry = mk_pair(7'h38, 7'h2A);  8'h46: entry = mk_pair(7'h39, 7'h28);
      8'h0E: entry = mk_pair(7'h60, 7'h7E);  8'h4E: entry = mk_pair(7'h2D, 7'h5F);
      8'h55: entry = mk_pair(7'h3D, 7'h2B);  8'h54: entry = mk_pair(7'h5B, 7'h7B);
      8'h5B: entry = mk_pair(7'h5D, 7'h7D);  8'h5D: entry = mk_pair(7'h5C, 7'h7C);
      8'h4C: entry = mk_pair(7'h3B, 7'h3A);  8'h52: entry = mk_pair(7'h27, 7'h22);
      8'h41: entry = mk_pair(7'h2C, 7'h3C);  8'h49: entry = mk_pair(7'h2E, 7'h3E);
      8'h4A: entry = mk_pair(7'h2F, 7'h3F);
      default: entry = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_kbd_decode: PS/2 Set-2 scancodes to queued PDP-8 console chars |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_kbd_decode
  import ps2_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter logic MARK_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ps2_kbd_decode_if.slave  bus,
  output logic             caps_lock,
  output logic             overrun,
  output logic             parity_err,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t     state;
  logic       lshift, rshift, lctrl, rctrl, caps_held;
  logic       dec_valid;
  logic [7:0] dec_char;
  map_entry_t map;

  logic       parity_ok, brk_st, ext_st, shift, ctrl, make_emit, use_shifted;
  logic [6:0] make_code;

  ps2_kbd_map u_map (
    .code  (bus.sc),
    .entry (map)
  );

  assign parity_ok = ^{bus.sc, bus.sc_parity};
  assign brk_st    = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign ext_st    = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign shift     = lshift | rshift;
  assign ctrl      = lctrl | rctrl;

  // Character a make of bus.sc would produce, using pre-edge modifier state.
  always_comb begin
    make_code   = 7'h00;
    make_emit   = 1'b0;
    use_shifted = map.is_letter ? (shift ^ caps_lock) : shift;
    if (ext_st) begin
      if (bus.sc == SC_ENTER) begin
        make_code = ASC_CR;
        make_emit = 1'b1;
      end else if (bus.sc == SC_KP_SLASH) begin
        make_code = ASC_SLASH;
        make_emit = 1'b1;
      end
    end else begin
      case (bus.sc)
        SC_ENTER: begin make_code = ASC_CR;     make_emit = 1'b1; end
        SC_BKSP:  begin make_code = ASC_RUBOUT; make_emit = 1'b1; end
        SC_ESC:   begin make_code = ASC_ESC;    make_emit = 1'b1; end
        SC_TAB:   begin make_code = ASC_TAB;    make_emit = 1'b1; end
        SC_SPACE: begin make_code = ASC_SPACE;  make_emit = 1'b1; end
        default: begin
          make_code = use_shifted ? map.shifted : map.unshifted;
          if (ctrl && make_code[6]) make_code = make_code & 7'h1F;
          make_emit = map.hit;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      lctrl      <= 1'b0;
      rctrl      <= 1'b0;
      caps_held  <= 1'b0;
      caps_lock  <= 1'b0;
      parity_err <= 1'b0;
      dec_valid  <= 1'b0;
      dec_char   <= 8'h00;
    end else begin
      dec_valid <= 1'b0;
      if (err_clr) parity_err <= 1'b0;
      if (bus.sc_error) begin
        state <= ST_IDLE;
      end else if (bus.sc_rdy) begin
        if (!parity_ok) begin
          parity_err <= 1'b1;
          state      <= ST_IDLE;
        end else if (bus.sc == SC_E0) begin
          state <= ST_EXT;
        end else if (bus.sc == SC_F0) begin
          if (state == ST_IDLE)     state <= ST_BRK;
          else if (state == ST_EXT) state <= ST_EXT_BRK;
        end else if (bus.sc == SC_E1) begin
          state <= state;
        end else if (is_discard(bus.sc)) begin
          state <= ST_IDLE;
        end else begin
          state <= ST_IDLE;
          if (!ext_st && bus.sc == SC_LSHIFT) lshift <= !brk_st;
          if (!ext_st && bus.sc == SC_RSHIFT) rshift <= !brk_st;
          if (!ext_st && bus.sc == SC_CTRL)   lctrl  <= !brk_st;
          if ( ext_st && bus.sc == SC_CTRL)   rctrl  <= !brk_st;
          // Typematic repeats of caps lock arrive with caps_held already set.
          if (!ext_st && bus.sc == SC_CAPS) begin
            if (!brk_st && !caps_held) caps_lock <= !caps_lock;
            caps_held <= !brk_st;
          end
          if (!brk_st && make_emit) begin
            dec_valid <= 1'b1;
            dec_char  <= {MARK_BIT, make_code};
          end
        end
      end
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty, pop, push_ok;

  assign not_empty = (count != '0);
  assign pop       = bus.char_ack && not_empty;
  assign push_ok   = dec_valid && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dec_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (err_clr) overrun <= 1'b0;
      if (dec_valid && !push_ok) overrun <= 1'b1;
    end
  end

  assign bus.char_valid = not_empty;
  assign bus.char       = not_empty ? mem[rd_ptr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_kbd_decode: vector table, corner sequences, random vs model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ps2_kbd_decode;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic caps_lock, overrun, parity_err;
    logic err_clr = 1'b0;

    ps2_kbd_decode_if bus ();

    ps2_kbd_decode #(.DEPTH(DEPTH), .MARK_BIT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .caps_lock  (caps_lock),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int          n;
        logic [47:0] codes;
        logic        has;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[21];

    // Reference keymap and key-down model.
    logic [6:0] lo_t[256];
    logic [6:0] hi_t[256];
    bit         let_t[256];
    bit         hit_t[256];
    bit         down[512];
    bit         m_brk, m_ext, m_caps, m_perr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] code, input logic bad = 1'b0);
        @(negedge clk);
        bus.sc        = code;
        bus.sc_parity = ~(^code) ^ bad;
        bus.sc_rdy    = 1'b1;
        @(negedge clk);
        bus.sc_rdy    = 1'b0;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            chk({name, " valid"}, bus.char_valid, 1);
            chk({name, " char"}, bus.char, exp_q.pop_front());
            bus.char_ack = 1'b1;
            @(negedge clk);
            bus.char_ack = 1'b0;
        end
        chk({name, " empty"}, bus.char_valid, 0);
    endtask

    task automatic build_map();
        logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] pc[11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
                               8'h49, 8'h4A};
        logic [6:0] dig_hi[10] = '{7'h29, 7'h21, 7'h40, 7'h23, 7'h24, 7'h25, 7'h5E, 7'h26,
                                   7'h2A, 7'h28};
        logic [6:0] pun_lo[11] = '{7'h60, 7'h2D, 7'h3D, 7'h5B, 7'h5D, 7'h5C, 7'h3B, 7'h27,
                                   7'h2C, 7'h2E, 7'h2F};
        logic [6:0] pun_hi[11] = '{7'h7E, 7'h5F, 7'h2B, 7'h7B, 7'h7D, 7'h7C, 7'h3A, 7'h22,
                                   7'h3C, 7'h3E, 7'h3F};
        for (int i = 0; i < 256; i++) begin
            hit_t[i] = 0; let_t[i] = 0; lo_t[i] = '0; hi_t[i] = '0;
        end
        for (int i = 0; i < 26; i++) begin
            hit_t[lc[i]] = 1; let_t[lc[i]] = 1;
            lo_t[lc[i]] = 7'(97 + i);
            hi_t[lc[i]] = 7'(65 + i);
        end
        for (int i = 0; i < 10; i++) begin
            hit_t[dc[i]] = 1;
            lo_t[dc[i]] = 7'(48 + i);
            hi_t[dc[i]] = dig_hi[i];
        end
        for (int i = 0; i < 11; i++) begin
            hit_t[pc[i]] = 1;
            lo_t[pc[i]] = pun_lo[i];
            hi_t[pc[i]] = pun_hi[i];
        end
    endtask

    task automatic model(input logic [7:0] code, input bit bad, input bit err);
        int key;
        int c;
        bit sh, ct;
        if (err) begin m_brk = 0; m_ext = 0; return; end
        if (bad) begin m_brk = 0; m_ext = 0; m_perr = 1; return; end
        case (code)
            8'hE0: begin m_ext = 1; m_brk = 0; end
            8'hF0: m_brk = 1;
            8'hE1: ;
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: begin m_brk = 0; m_ext = 0; end
            default: begin
                key = (m_ext ? 256 : 0) + int'(code);
                if (m_brk) begin
                    down[key] = 0;
                end else begin
                    sh = down['h012] | down['h059];
                    ct = down['h014] | down['h114];
                    c  = -1;
                    if (m_ext) begin
                        if (code == 8'h5A) c = 13;
                        else if (code == 8'h4A) c = 47;
                    end else if (code == 8'h5A) c = 13;
                    else if (code == 8'h66) c = 127;
                    else if (code == 8'h76) c = 27;
                    else if (code == 8'h0D) c = 9;
                    else if (code == 8'h29) c = 32;
                    else if (hit_t[code]) begin
                        c = ((let_t[code] ? (sh ^ m_caps) : sh) ? int'(hi_t[code]) : int'(lo_t[code]));
                        if (ct && c >= 64) c = c % 32;
                    end
                    if (key == 'h058 && !down[key]) m_caps = !m_caps;
                    down[key] = 1;
                    if (c >= 0) exp_q.push_back(8'(c) | 8'h80);
                end
                m_brk = 0;
                m_ext = 0;
            end
        endcase
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] lc[8] = '{8'h1C, 8'h32, 8'h21, 8'h2D, 8'h1A, 8'h43, 8'h35, 8'h4B};
        logic [7:0] oc[16] = '{8'h16, 8'h45, 8'h1E, 8'h36, 8'h0E, 8'h4E, 8'h54, 8'h52,
                               8'h4A, 8'h5A, 8'h66, 8'h76, 8'h0D, 8'h29, 8'hAA, 8'hE1};
        logic [7:0] mc[4] = '{8'h12, 8'h59, 8'h14, 8'h58};
        int r = $urandom_range(0, 99);
        if (r < 35) return lc[$urandom_range(0, 7)];
        if (r < 55) return oc[$urandom_range(0, 15)];
        if (r < 70) return mc[$urandom_range(0, 3)];
        if (r < 82) return 8'hF0;
        if (r < 92) return 8'hE0;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] code;
        bit bad, err;

        bus.sc = 8'h00; bus.sc_parity = 1'b1; bus.sc_rdy = 1'b0;
        bus.sc_error = 1'b0; bus.char_ack = 1'b0;
        build_map();

        vecs[0]  = '{3, 48'h1C_F0_1C, 1'b1, 8'hE1};
        vecs[1]  = '{6, 48'h12_16_F0_16_F0_12, 1'b1, 8'hA1};
        vecs[2]  = '{4, 48'h58_F0_58_1C, 1'b1, 8'hC1};
        vecs[3]  = '{2, 48'h14_21, 1'b1, 8'h83};
        vecs[4]  = '{3, 48'hE0_14_2D, 1'b1, 8'h92};
        vecs[5]  = '{2, 48'hE0_5A, 1'b1, 8'h8D};
        vecs[6]  = '{2, 48'hE0_75, 1'b0, 8'h00};
        vecs[7]  = '{2, 48'hE0_4A, 1'b1, 8'hAF};
        vecs[8]  = '{1, 48'h66, 1'b1, 8'hFF};
        vecs[9]  = '{1, 48'h76, 1'b1, 8'h9B};
        vecs[10] = '{1, 48'h0D, 1'b1, 8'h89};
        vecs[11] = '{1, 48'h29, 1'b1, 8'hA0};
        vecs[12] = '{3, 48'hF0_AA_1C, 1'b1, 8'hE1};
        vecs[13] = '{3, 48'hF0_E1_1C, 1'b0, 8'h00};
        vecs[14] = '{3, 48'hE0_12_1C, 1'b1, 8'hE1};
        vecs[15] = '{3, 48'h12_58_1C, 1'b1, 8'hE1};
        vecs[16] = '{3, 48'h58_12_16, 1'b1, 8'hA1};
        vecs[17] = '{4, 48'h12_F0_12_1C, 1'b1, 8'hE1};
        vecs[18] = '{3, 48'h59_14_1C, 1'b1, 8'h81};
        vecs[19] = '{4, 48'h14_F0_14_26, 1'b1, 8'hB3};
        vecs[20] = '{2, 48'h14_4E, 1'b1, 8'hAD};

        do_reset();
        chk("reset char_valid", bus.char_valid, 0);
        chk("reset char", bus.char, 8'h00);
        chk("reset caps_lock", caps_lock, 0);
        chk("reset overrun", overrun, 0);
        chk("reset parity_err", parity_err, 0);

        foreach (vecs[v]) begin
            do_reset();
            for (int j = 0; j < vecs[v].n; j++)
                send(vecs[v].codes[8*(vecs[v].n-1-j) +: 8]);
            @(negedge clk);
            if (vecs[v].has) exp_q.push_back(vecs[v].exp);
            drain($sformatf("vec%0d", v));
        end

        do_reset();
        send(8'h1C);
        chk("latency after E", bus.char_valid, 0);
        @(negedge clk);
        chk("latency after E+1", bus.char_valid, 1);
        exp_q.push_back(8'hE1);
        drain("latency");

        do_reset();
        repeat (3) send(8'h58);
        chk("caps typematic", caps_lock, 1);
        send(8'hF0); send(8'h58);
        chk("caps break", caps_lock, 1);
        send(8'h58);
        chk("caps second press", caps_lock, 0);
        @(negedge clk);
        drain("caps none");

        do_reset();
        send(8'h1C, 1'b1);
        @(negedge clk);
        chk("parity_err set", parity_err, 1);
        drain("bad parity");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("parity_err clear", parity_err, 0);
        @(negedge clk);
        bus.sc = 8'h1C; bus.sc_parity = ^8'h1C; bus.sc_rdy = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        bus.sc_rdy = 1'b0; err_clr = 1'b0;
        chk("parity_err set wins", parity_err, 1);

        do_reset();
        repeat (DEPTH + 2) send(8'h1C);
        @(negedge clk);
        chk("overrun set", overrun, 1);
        repeat (DEPTH) exp_q.push_back(8'hE1);
        drain("overrun fill");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("overrun clear", overrun, 0);

        do_reset();
        repeat (DEPTH) send(8'h1C);
        @(negedge clk);
        bus.sc = 8'h32; bus.sc_parity = ~(^8'h32); bus.sc_rdy = 1'b1;
        @(negedge clk);
        bus.sc_rdy = 1'b0; bus.char_ack = 1'b1;
        @(negedge clk);
        bus.char_ack = 1'b0;
        chk("full push+pop overrun", overrun, 0);
        repeat (DEPTH - 1) exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        drain("full push+pop");

        do_reset();
        send(8'hF0);
        @(negedge clk); bus.sc_error = 1'b1;
        @(negedge clk); bus.sc_error = 1'b0;
        send(8'h1C);
        @(negedge clk);
        exp_q.push_back(8'hE1);
        drain("error clears brk");
        @(negedge clk);
        bus.sc = 8'h1C; bus.sc_parity = ~(^8'h1C); bus.sc_rdy = 1'b1; bus.sc_error = 1'b1;
        @(negedge clk);
        bus.sc_rdy = 1'b0; bus.sc_error = 1'b0;
        @(negedge clk);
        drain("error ignores code");

        do_reset();
        send(8'h58); send(8'h1C); send(8'hE0);
        @(negedge clk);
        do_reset();
        chk("midrst char_valid", bus.char_valid, 0);
        chk("midrst char", bus.char, 8'h00);
        chk("midrst caps_lock", caps_lock, 0);
        chk("midrst overrun", overrun, 0);
        chk("midrst parity_err", parity_err, 0);
        send(8'h1C);
        @(negedge clk);
        exp_q.push_back(8'hE1);
        drain("midrst prefix");

        do_reset();
        for (int i = 0; i < 512; i++) down[i] = 0;
        m_brk = 0; m_ext = 0; m_caps = 0; m_perr = 0;
        for (int it = 0; it < 400; it++) begin
            code = rand_code();
            bad  = ($urandom_range(0, 99) < 3);
            err  = ($urandom_range(0, 99) < 2);
            @(negedge clk);
            bus.sc = code; bus.sc_parity = ~(^code) ^ bad; bus.sc_rdy = 1'b1; bus.sc_error = err;
            @(negedge clk);
            bus.sc_rdy = 1'b0; bus.sc_error = 1'b0;
            model(code, bad, err);
            @(negedge clk);
            drain($sformatf("rand%0d", it));
            chk($sformatf("rand%0d caps", it), caps_lock, m_caps);
            chk($sformatf("rand%0d perr", it), parity_err, m_perr);
            if (m_perr) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                m_perr = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
